// File: rtl/store_buffer_pkg.sv
// Shared constants and helpers for the posted-store buffer: memory geometry,
// funct3 encodings, access-size decode and load extension.
package store_buffer_pkg;

    localparam int MEM_SIZE         = 4096;
    localparam int INSTRUCTION_SIZE = 32;
    localparam int SB_DEPTH         = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size minus one, from funct3[1:0]: byte=0, half=1, word=3.
    function automatic logic [1:0] size_m1(input logic [1:0] sz);
        case (sz)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic is_store_f3(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    function automatic logic [INSTRUCTION_SIZE-1:0] load_extend(
        input logic [INSTRUCTION_SIZE-1:0] d,
        input logic [2:0]                  f3
    );
        case (f3)
            F3_B:    return {{24{d[7]}}, d[7:0]};
            F3_H:    return {{16{d[15]}}, d[15:0]};
            F3_BU:   return {24'd0, d[7:0]};
            F3_HU:   return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_overlap.sv
// Combinational byte-range intersection of one queued store against the
// current load; ranges use one extra address bit so nothing wraps at the top.
module store_buffer_overlap
    import store_buffer_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              entry_valid,
    input  logic [ADDR_W-1:0] entry_addr,
    input  logic [1:0]        entry_size,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    output logic              overlap
);

    logic [ADDR_W:0] st_lo;
    logic [ADDR_W:0] st_hi;
    logic [ADDR_W:0] ld_lo;
    logic [ADDR_W:0] ld_hi;

    assign st_lo = {1'b0, entry_addr};
    assign ld_lo = {1'b0, ld_addr};
    assign st_hi = st_lo + {{(ADDR_W-1){1'b0}}, size_m1(entry_size)};
    assign ld_hi = ld_lo + {{(ADDR_W-1){1'b0}}, size_m1(ld_size)};

    assign overlap = entry_valid && (st_lo <= ld_hi) && (ld_lo <= st_hi);

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO between the core memory stage and data memory; drains one
// store per load-free cycle. Define STORE_BUFFER_FWD_EN for store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = $clog2(MEM_SIZE),
    parameter int DATA_W = INSTRUCTION_SIZE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [2:0]                 st_funct3,
    input  logic                       ld_req,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [2:0]                 ld_funct3,
    output logic                       ld_stall,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       dm_mem_read,
    output logic                       dm_mem_write,
    output logic [ADDR_W-1:0]          dm_address,
    output logic [DATA_W-1:0]          dm_write_data,
    output logic [2:0]                 dm_funct3,
    input  logic [DATA_W-1:0]          dm_read_data,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH+1)-1:0] sb_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  ent_valid;
    logic [ADDR_W-1:0] ent_addr   [DEPTH];
    logic [DATA_W-1:0] ent_data   [DEPTH];
    logic [2:0]        ent_funct3 [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [DEPTH-1:0]  overlap;
    logic              any_overlap;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              do_enq;
    logic              do_deq;
    logic              drain_go;

    assign st_ready = !reset && (count < CNT_W'(DEPTH));
    assign do_enq   = st_valid && st_ready && is_store_f3(st_funct3);
    assign sb_empty = (count == '0);
    assign sb_count = count;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ovl
        store_buffer_overlap #(
            .ADDR_W (ADDR_W)
        ) u_overlap (
            .entry_valid (ent_valid[g]),
            .entry_addr  (ent_addr[g]),
            .entry_size  (ent_funct3[g][1:0]),
            .ld_addr     (ld_addr),
            .ld_size     (ld_funct3[1:0]),
            .overlap     (overlap[g])
        );
    end

    assign any_overlap = |overlap;

`ifdef STORE_BUFFER_FWD_EN
    logic [PTR_W-1:0] yng_idx;

    // Walk oldest to youngest so the last hit is the most recent store.
    always_comb begin
        yng_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            if (overlap[head + PTR_W'(i)]) begin
                yng_idx = head + PTR_W'(i);
            end
        end
    end

    assign fwd_hit  = ld_req && any_overlap
                      && (ent_addr[yng_idx] == ld_addr)
                      && (size_m1(ent_funct3[yng_idx][1:0]) >= size_m1(ld_funct3[1:0]));
    assign fwd_data = load_extend(ent_data[yng_idx], ld_funct3);
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    assign ld_stall = !reset && ld_req && any_overlap && !fwd_hit;
    assign drain_go = (count != '0) && (!ld_req || ld_stall || fwd_hit);
    assign do_deq   = drain_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (do_enq) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (do_deq) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: an entry is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            ent_addr[tail]   <= st_addr;
            ent_data[tail]   <= st_data;
            ent_funct3[tail] <= st_funct3;
        end
    end

    always_comb begin
        dm_mem_read   = 1'b0;
        dm_mem_write  = 1'b0;
        dm_address    = '0;
        dm_write_data = '0;
        dm_funct3     = '0;
        ld_data       = '0;
        if (!reset) begin
            if (drain_go) begin
                dm_mem_write  = 1'b1;
                dm_address    = ent_addr[head];
                dm_write_data = ent_data[head];
                dm_funct3     = ent_funct3[head];
            end else if (ld_req && !ld_stall && !fwd_hit) begin
                dm_mem_read = 1'b1;
                dm_address  = ld_addr;
                dm_funct3   = ld_funct3;
                ld_data     = dm_read_data;
            end
            if (fwd_hit) begin
                ld_data = fwd_data;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: byte-addressable memory model, write
// scoreboard fed at store acceptance, and an architectural reference for loads.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [11:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        ld_req;
    logic [11:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic        ld_stall;
    logic [31:0] ld_data;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [11:0] dm_address;
    logic [31:0] dm_write_data;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_read_data;
    logic        sb_empty;
    logic [2:0]  sb_count;

    store_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_funct3     (st_funct3),
        .ld_req        (ld_req),
        .ld_addr       (ld_addr),
        .ld_funct3     (ld_funct3),
        .ld_stall      (ld_stall),
        .ld_data       (ld_data),
        .dm_mem_read   (dm_mem_read),
        .dm_mem_write  (dm_mem_write),
        .dm_address    (dm_address),
        .dm_write_data (dm_write_data),
        .dm_funct3     (dm_funct3),
        .dm_read_data  (dm_read_data),
        .sb_empty      (sb_empty),
        .sb_count      (sb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic [2:0]  f;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_ld[$];
    logic [7:0]  mem      [0:4099];
    logic [7:0]  ref_arch [0:4099];
    logic [7:0]  ref_save [0:4099];
    int          n_vec = 0;
    int          n_miscomp = 0;
    int          wr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscomp++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f);
        case (f)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [11:0] a, input logic [2:0] f);
        int i;
        i = int'(a);
        return ext({ref_arch[i+3], ref_arch[i+2], ref_arch[i+1], ref_arch[i]}, f);
    endfunction

    // Data memory model: combinational extended read, byte-enabled write at posedge.
    always_comb begin
        int i;
        i = int'(dm_address);
        dm_read_data = ext({mem[i+3], mem[i+2], mem[i+1], mem[i]}, dm_funct3);
    end

    always @(posedge clk) begin
        if (dm_mem_write) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0 || (k == 1 && dm_funct3[1:0] != 2'b00) || dm_funct3[1:0] == 2'b10)
                    mem[int'(dm_address) + k] = dm_write_data[8*k +: 8];
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        check("port_excl", {31'd0, dm_mem_read & dm_mem_write}, 32'd0);
        if (dm_mem_write) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", {20'd0, dm_address}, {20'd0, e.a});
                check("wr_data", dm_write_data, e.d);
                check("wr_f3", {29'd0, dm_funct3}, {29'd0, e.f});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_store(input logic [11:0] a, input logic [31:0] d, input logic [2:0] f);
        int n;
        wr_t e;
        n = 0;
        st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f;
        @(negedge clk);
        while (!st_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!st_ready) begin
            check("st_timeout", 32'd1, 32'd0);
            st_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (f == 3'b000 || f == 3'b001 || f == 3'b010) begin
                e.a = a; e.d = d; e.f = f;
                exp_wr.push_back(e);
                for (int k = 0; k < 4; k++) begin
                    if (k == 0 || (k == 1 && f != 3'b000) || f == 3'b010)
                        ref_arch[int'(a) + k] = d[8*k +: 8];
                end
            end
            #1;
            st_valid = 1'b0;
        end
    endtask

    task automatic do_load(input logic [11:0] a, input logic [2:0] f,
                           output int stalls, output logic rd);
        logic [31:0] exp;
        exp_ld.push_back(ref_read(a, f));
        ld_req = 1'b1; ld_addr = a; ld_funct3 = f;
        stalls = 0;
        @(negedge clk);
        while (ld_stall && stalls < 20) begin
            check("ld_data_stalled", ld_data, 32'd0);
            check("rd_stalled", {31'd0, dm_mem_read}, 32'd0);
            stalls++;
            @(negedge clk);
        end
        exp = exp_ld.pop_front();
        if (ld_stall) check("ld_timeout", 32'd1, 32'd0);
        else          check("ld_data", ld_data, exp);
        rd = dm_mem_read;
        @(posedge clk);
        #1;
        ld_req = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        @(negedge clk);
        while (!sb_empty && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", {31'd0, sb_empty}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          st;
        logic        rd;
        int          base;
        for (int i = 0; i < 4100; i++) begin
            mem[i] = 8'h00;
            ref_arch[i] = 8'h00;
        end
        reset = 1'b1;
        st_valid = 1'b1; st_addr = 12'h100; st_data = 32'h1; st_funct3 = 3'b010;
        ld_req = 1'b1; ld_addr = 12'h100; ld_funct3 = 3'b010;
        @(negedge clk);
        @(negedge clk);
        check("rst_st_ready", {31'd0, st_ready}, 32'd0);
        check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("rst_sb_count", {29'd0, sb_count}, 32'd0);
        check("rst_dm_write", {31'd0, dm_mem_write}, 32'd0);
        check("rst_dm_read", {31'd0, dm_mem_read}, 32'd0);
        check("rst_dm_addr", {20'd0, dm_address}, 32'd0);
        check("rst_ld_stall", {31'd0, ld_stall}, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        st_valid = 1'b0; ld_req = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Sub-word store pending under a word load: one stall, then merged data.
        do_store(12'h103, 32'h0000_00AB, 3'b000);
        do_load(12'h100, 3'b010, st, rd);
        check("sb_lw_stalls", st, 32'd1);
        check("sb_lw_value", {mem[259], mem[258], mem[257], mem[256]}, 32'hAB00_0000);

        // Store then idle: write reaches memory the following cycle.
        do_store(12'h100, 32'hDEAD_BEEF, 3'b010);
        @(negedge clk);
        check("lat_write", {31'd0, dm_mem_write}, 32'd1);
        check("lat_addr", {20'd0, dm_address}, 32'h100);
        @(posedge clk);
        #1;
        do_load(12'h100, 3'b010, st, rd);
        check("lw_nostall", st, 32'd0);
        check("lw_rd", {31'd0, rd}, 32'd1);

        // Adjacent but disjoint ranges do not stall; a shared byte does.
        do_store(12'h0FE, 32'h1234_5678, 3'b001);
        do_load(12'h100, 3'b000, st, rd);
        check("adj_nostall", st, 32'd0);
        do_load(12'h0FF, 3'b000, st, rd);
        check("ovl_stall", st, 32'd1);
        wait_empty();

        // Range near top of memory must not wrap onto low addresses.
        do_store(12'hFFE, 32'hCAFE_F00D, 3'b010);
        do_load(12'h001, 3'b100, st, rd);
        check("nowrap_nostall", st, 32'd0);
        wait_empty();

        // Unsupported store size completes the handshake but is dropped.
        do_store(12'h500, 32'h5555_5555, 3'b011);
        @(negedge clk);
        check("illegal_count", {29'd0, sb_count}, 32'd0);
        check("illegal_nowrite", {31'd0, dm_mem_write}, 32'd0);
        @(posedge clk);
        #1;

        // Fill while a disjoint load holds the port, then drain back to back.
        ld_req = 1'b1; ld_addr = 12'h300; ld_funct3 = 3'b010;
        base = wr_cnt;
        for (int i = 0; i < 4; i++)
            do_store(12'h010 + 12'(4*i), 32'hA000_0000 + i, 3'b010);
        @(negedge clk);
        check("full_count", {29'd0, sb_count}, 32'd4);
        check("full_ready", {31'd0, st_ready}, 32'd0);
        check("full_nowrites", wr_cnt, base);
        check("full_ld_stall", {31'd0, ld_stall}, 32'd0);
        check("full_ld_data", ld_data, 32'd0);
        @(posedge clk);
        #1;
        ld_req = 1'b0;
        @(negedge clk);
        check("full_deq_ready", {31'd0, st_ready}, 32'd0);
        check("full_deq_write", {31'd0, dm_mem_write}, 32'd1);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        check("drain4_empty", {31'd0, sb_empty}, 32'd1);
        check("drain4_writes", wr_cnt, base + 4);

        // Reset with pending stores discards them all.
        for (int i = 0; i < 4100; i++) ref_save[i] = ref_arch[i];
        ld_req = 1'b1; ld_addr = 12'h300; ld_funct3 = 3'b010;
        for (int i = 0; i < 3; i++)
            do_store(12'h400 + 12'(4*i), 32'h7777_0000 + i, 3'b010);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_count", {29'd0, sb_count}, 32'd0);
        check("mid_rst_write", {31'd0, dm_mem_write}, 32'd0);
        exp_wr.delete();
        for (int i = 0; i < 4100; i++) ref_arch[i] = ref_save[i];
        base = wr_cnt;
        @(negedge clk);
        @(negedge clk);
        ld_req = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        check("post_rst_writes", wr_cnt, base);
        check("post_rst_empty", {31'd0, sb_empty}, 32'd1);
        check("post_rst_mem", {mem[1035], mem[1034], mem[1033], mem[1032]}, 32'd0);
        check("post_rst_mem0", {mem[1027], mem[1026], mem[1025], mem[1024]}, 32'd0);

        // Exact-address word store under a byte load.
        do_store(12'h200, 32'h8000_FF80, 3'b010);
        do_load(12'h200, 3'b000, st, rd);
`ifdef STORE_BUFFER_FWD_EN
        check("fwd_stalls", st, 32'd0);
        check("fwd_no_read", {31'd0, rd}, 32'd0);
`else
        check("nofwd_stalls", st, 32'd1);
        check("nofwd_read", {31'd0, rd}, 32'd1);
`endif
        wait_empty();

        // Store narrower than the load always stalls.
        do_store(12'h204, 32'h0000_0011, 3'b000);
        do_load(12'h204, 3'b010, st, rd);
        check("narrow_stalls", st, 32'd1);
        wait_empty();

        repeat (3) @(posedge clk);
        check("sbq_left", exp_wr.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-store buffer between the single-cycle core's memory stage and the byte-addressable data memory.
- Accepts SB/SH/SW from the core in one cycle and queues them in a circular FIFO.
- Drains one store per cycle into the data memory write port whenever the core is not issuing a load.
- Detects byte-range overlap between a load and queued stores; stalls that load until the hazard clears.

Parameters:
- DEPTH, 4, number of store entries; power of two, ≥2.
- ADDR_W, $clog2(`MEM_SIZE), byte-address width of the data memory.
- DATA_W, `INSTRUCTION_SIZE (32), store/load data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- st_valid  in  1  core presents a store.
- st_ready  out  1  buffer can accept a store.
- st_addr  in  ADDR_W  store byte address.
- st_data  in  DATA_W  store data, LSB-aligned.
- st_funct3  in  3  000 SB, 001 SH, 010 SW.
- ld_req  in  1  core issues a load this cycle.
- ld_addr  in  ADDR_W  load byte address.
- ld_funct3  in  3  LB/LH/LW/LBU/LHU encoding.
- ld_stall  out  1  load must be held; core freezes the PC.
- ld_data  out  DATA_W  load result.
- dm_mem_read  out  1  to data memory mem_read.
- dm_mem_write  out  1  to data memory mem_write.
- dm_address  out  ADDR_W  to data memory address.
- dm_write_data  out  DATA_W  to data memory write_data.
- dm_funct3  out  3  to data memory funct3.
- dm_read_data  in  DATA_W  from data memory read_data.
- sb_empty  out  1  no pending stores (fence/ecall drain check).
- sb_count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - head, tail and count go to 0; all entries are invalidated.
  - st_ready=0 while reset is high; sb_empty=1; sb_count=0.
  - All dm_* outputs, ld_stall and ld_data are 0.
  - Reset mid-drain discards every pending store; no partial write is issued.
- Enqueue:
  - st_ready = (count < DEPTH).
  - A store is accepted at posedge when st_valid & st_ready; the entry is written at tail, tail advances modulo DEPTH.
  - st_funct3 other than 000/001/010 is consumed (handshake completes) but not queued.
- Drain:
  - drain_go = (count>0) & (!ld_req | ld_stall).
  - The head entry drives dm_mem_write=1, dm_address, dm_write_data and dm_funct3 combinationally.
  - The entry dequeues at the same posedge at which the data memory commits it.
  - Latency: a store accepted at edge N reaches memory at edge N+1 at the earliest.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - When full, st_ready=0 even if a dequeue occurs that cycle (no full bypass).
- Load path:
  - Size = 1/2/4 bytes from funct3[1:0].
  - Overlap is computed when the byte ranges [a, a+size-1] of the load and any valid entry intersect.
  - Range arithmetic uses ADDR_W+1 bits; there is no wrap at the top of memory.
  - ld_stall = ld_req & any_overlap.
  - While not stalled: dm_mem_read=1 and dm_address/dm_funct3 come from ld_*; ld_data = dm_read_data.
  - While stalled, or with no ld_req: dm_mem_read=0 and ld_data=0.
  - Forward progress is guaranteed because draining continues during a stall.
- Arbitration: a load and a drain never share the port in the same cycle.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- With the macro defined:
  - Only the youngest overlapping entry is considered.
  - If it has the same address as the load and store size ≥ load size, ld_data is taken from that entry's data, sign/zero-extended per ld_funct3.
  - In that case ld_stall=0, dm_mem_read=0, and draining proceeds that cycle.
  - Any other overlap stalls.
- Without the macro: every overlap stalls.

Decomposition:
- RISCV_PKG.vh constants: MEM_SIZE, INSTRUCTION_SIZE, funct3 encodings (F3_B/H/W/BU/HU), SB_DEPTH default.
- Sub-module: store_buffer_overlap, a purely combinational range compare of one entry against the load, instantiated DEPTH times.

Test Plan:
- SW 0x100=0xDEADBEEF, then idle → next cycle dm_mem_write=1, addr 0x100; a later LW 0x100 returns 0xDEADBEEF with ld_stall=0.
- Hold a non-overlapping LW 0x300, enqueue 4 SW → sb_count=4, st_ready=0, no dm writes; drop ld_req → 4 consecutive writes, sb_empty=1 after 4 cycles.
- SB 0x103=0xAB pending, LW 0x100 → ld_stall=1 for one cycle while the drain writes, then ld_data=0xAB000000 (memory zero-initialised).
- SH 0x0FE pending, LB 0x100 → no stall; LB 0x0FF → stall.
- Enqueue 3 stores, assert reset between edges → sb_count=0, no dm_mem_write after release, memory untouched.
- STORE_BUFFER_FWD_EN defined: SW 0x200=0x8000FF80, LB 0x200 → ld_data=0xFFFFFF80, ld_stall=0, dm_mem_read=0.
